// File: rtl/xo_instr_decoder_pkg.sv
// uPower XO-form field positions, opcodes and field record.
// Shared by the decoder, its bus interface and the bench.
package uPower_isa_pkg;

    localparam int PO_MSB = 31;
    localparam int PO_LSB = 26;
    localparam int RT_MSB = 25;
    localparam int RT_LSB = 21;
    localparam int RA_MSB = 20;
    localparam int RA_LSB = 16;
    localparam int RB_MSB = 15;
    localparam int RB_LSB = 11;
    localparam int OE_BIT = 10;
    localparam int XO_MSB = 9;
    localparam int XO_LSB = 1;
    localparam int RC_BIT = 0;

    localparam logic [5:0] PO_XO    = 6'd31;
    localparam logic [8:0] XO_ADD   = 9'd266;
    localparam logic [8:0] XO_SUBF  = 9'd40;
    localparam logic [8:0] XO_ADDC  = 9'd10;
    localparam logic [8:0] XO_SUBFC = 9'd8;
    localparam logic [8:0] XO_NEG   = 9'd104;
    localparam logic [8:0] XO_AND   = 9'd28;

    typedef struct packed {
        logic [5:0] po;
        logic [4:0] rt;
        logic [4:0] ra;
        logic [4:0] rb;
        logic       oe;
        logic [8:0] xo;
        logic       rc;
    } xo_fields_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_e;

    function automatic xo_fields_t split_fields(input logic [31:0] w);
        xo_fields_t f;
        f.po = w[PO_MSB:PO_LSB];
        f.rt = w[RT_MSB:RT_LSB];
        f.ra = w[RA_MSB:RA_LSB];
        f.rb = w[RB_MSB:RB_LSB];
        f.oe = w[OE_BIT];
        f.xo = w[XO_MSB:XO_LSB];
        f.rc = w[RC_BIT];
        return f;
    endfunction

    // OE and Rc never affect legality; the full 9-bit XO is compared.
    function automatic logic is_legal_xo(input xo_fields_t f);
        return (f.po == PO_XO) &&
               (f.xo == XO_ADD  || f.xo == XO_SUBF || f.xo == XO_ADDC ||
                f.xo == XO_SUBFC || f.xo == XO_NEG || f.xo == XO_AND);
    endfunction

endpackage

// File: rtl/xo_instr_decoder_if.sv
// Instruction-in / fields-out bus of the XO decoder.
// Both channels: a transfer happens on a rising clk edge where valid && ready;
// once valid is high the source holds it and its payload until that transfer.
interface xo_instr_decoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  PO;
    logic [4:0]  rt;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        OE;
    logic [8:0]  XO;
    logic        Rc;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, PO, rt, ra, rb, OE, XO, Rc
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, PO, rt, ra, rb, OE, XO, Rc
    );
endinterface

// File: rtl/xo_instr_decoder_fifo.sv
// Instruction FIFO: DEPTH x W circular buffer with wrap-bit pointers.
// Head word is visible on rdata whenever empty is low.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign count = wr_ptr - rd_ptr;
    assign full  = (count == FULL_CNT);
    assign empty = (wr_ptr == rd_ptr);
    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/xo_instr_decoder.sv
// XO-format instruction decoder: FIFO-buffered input, one output register
// stage that drops unsupported words and counts them.
module xo_instr_decoder
    import uPower_isa_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    xo_instr_decoder_if.slave        bus,
    output logic                     illegal,
    output logic [CNT_W-1:0]         illegal_cnt,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output out_state_e               dbg_state
);
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic [31:0] head;

    out_state_e  state;
    out_state_e  state_nxt;
    xo_fields_t  head_f;
    xo_fields_t  fields_q;
    xo_fields_t  fields_nxt;
    logic        head_legal;
    logic        illegal_nxt;

    // in_ready comes only from registered occupancy, never from out_ready.
    assign bus.in_ready = !fifo_full;

    instr_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (bus.in_valid && bus.in_ready),
        .wdata (bus.in_instr),
        .pop   (fifo_pop),
        .rdata (head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_f     = split_fields(head);
    assign head_legal = is_legal_xo(head_f);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_EMPTY;
            fields_q    <= '0;
            illegal     <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            state    <= state_nxt;
            fields_q <= fields_nxt;
            illegal  <= illegal_nxt;
            if (illegal_nxt && (illegal_cnt != {CNT_W{1'b1}}))
                illegal_cnt <= illegal_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        fields_nxt  = fields_q;
        fifo_pop    = 1'b0;
        illegal_nxt = 1'b0;
        case (state)
            ST_EMPTY: fifo_pop = !fifo_empty;
            ST_HOLD: begin
                if (bus.out_ready) begin
                    if (!fifo_empty) fifo_pop  = 1'b1;
                    else             state_nxt = ST_EMPTY;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // A popped word either becomes the new output or is dropped outright.
        if (fifo_pop) begin
            if (head_legal) begin
                fields_nxt = head_f;
                state_nxt  = ST_HOLD;
            end else begin
                illegal_nxt = 1'b1;
                state_nxt   = ST_EMPTY;
            end
        end
    end

    assign bus.out_valid = (state == ST_HOLD);
    assign bus.PO        = fields_q.po;
    assign bus.rt        = fields_q.rt;
    assign bus.ra        = fields_q.ra;
    assign bus.rb        = fields_q.rb;
    assign bus.OE        = fields_q.oe;
    assign bus.XO        = fields_q.xo;
    assign bus.Rc        = fields_q.rc;
    assign dbg_state     = state;

endmodule

// File: tb/tb_xo_instr_decoder.sv
// Self-checking bench for xo_instr_decoder: directed sequences, a vector
// table and randomized traffic scored against a field-level reference model.
module tb_xo_instr_decoder;
  import uPower_isa_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xo_instr_decoder_if u_if ();
  xo_instr_decoder_if s_if ();

  logic        ill, s_ill;
  logic [15:0] ill_cnt;
  logic [3:0]  s_cnt;
  logic [2:0]  fcount, s_fcount;
  out_state_e  st, s_st;

  xo_instr_decoder #(.DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(u_if), .illegal(ill),
    .illegal_cnt(ill_cnt), .fifo_count(fcount), .dbg_state(st)
  );

  xo_instr_decoder #(.DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(s_if), .illegal(s_ill),
    .illegal_cnt(s_cnt), .fifo_count(s_fcount), .dbg_state(s_st)
  );

  // scoreboard state
  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  int hs_cnt = 0;
  int ill_pulses = 0;
  int s_pulses = 0;
  int exp_ill = 0;
  int ill_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // reference model: fields are plain bit-range arithmetic on the word
  function automatic logic [31:0] enc(input int po, input int rt, input int ra, input int rb,
                                      input int oe, input int xo, input int rc);
    return 32'(po * (1 << 26) + rt * (1 << 21) + ra * (1 << 16) + rb * (1 << 11)
               + oe * (1 << 10) + xo * 2 + rc);
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    int unsigned u = w;
    int unsigned po = u / (1 << 26);
    int unsigned xo = (u / 2) % 512;
    return (po == 31) && (xo == 266 || xo == 40 || xo == 10 || xo == 8 || xo == 104 || xo == 28);
  endfunction

  function automatic logic [31:0] ref_fields(input logic [31:0] w);
    int unsigned u = w;
    return enc(int'(u / (1 << 26)), int'((u / (1 << 21)) % 32), int'((u / (1 << 16)) % 32),
               int'((u / (1 << 11)) % 32), int'((u / (1 << 10)) % 2), int'((u / 2) % 512),
               int'(u % 2));
  endfunction

  function automatic logic [31:0] gen_word();
    int xo_list[6] = '{266, 40, 10, 8, 104, 28};
    if ($urandom_range(0, 1) == 1)
      return enc(31, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 1), xo_list[$urandom_range(0, 5)], $urandom_range(0, 1));
    return $urandom;
  endfunction

  // output monitor: a transfer is sampled just after the negedge, where
  // out_valid and out_ready both hold through the next rising edge
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (u_if.out_valid && u_if.out_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=0x%08h required=none",
                   {u_if.PO, u_if.rt, u_if.ra, u_if.rb, u_if.OE, u_if.XO, u_if.Rc});
        end else begin
          check("out_fields", {u_if.PO, u_if.rt, u_if.ra, u_if.rb, u_if.OE, u_if.XO, u_if.Rc},
                exp_q.pop_front());
        end
      end
      if (ill) ill_pulses++;
      if (s_ill) s_pulses++;
    end
  end

  // driver tasks (called at a negedge, return at a negedge)
  task automatic push(input logic [31:0] w, input bit legal, input logic [31:0] exp_f);
    int budget = 0;
    u_if.in_valid = 1'b1;
    u_if.in_instr = w;
    while (!u_if.in_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("push_accept", u_if.in_ready, 1);
    if (u_if.in_ready) begin
      if (legal) exp_q.push_back(exp_f);
      else begin
        exp_ill++;
        ill_total++;
      end
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget = 0;
    u_if.out_ready = 1'b1;
    while ((exp_q.size() != 0 || fcount != 0 || u_if.out_valid) && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  typedef struct {
    logic [31:0] instr;
    bit          legal;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  initial begin
    int hs0;
    logic [31:0] cur;
    bit pending;

    vecs[0]  = '{32'h7C632214, 1'b1, enc(31, 3, 3, 4, 0, 266, 0)};
    vecs[1]  = '{32'h7C8300D1, 1'b1, enc(31, 4, 3, 0, 0, 104, 1)};
    vecs[2]  = '{enc(31, 5, 6, 7, 1, 40, 0), 1'b1, enc(31, 5, 6, 7, 1, 40, 0)};
    vecs[3]  = '{enc(31, 31, 0, 17, 0, 10, 1), 1'b1, enc(31, 31, 0, 17, 0, 10, 1)};
    vecs[4]  = '{enc(31, 1, 2, 3, 1, 8, 1), 1'b1, enc(31, 1, 2, 3, 1, 8, 1)};
    vecs[5]  = '{enc(31, 9, 8, 7, 0, 28, 0), 1'b1, enc(31, 9, 8, 7, 0, 28, 0)};
    vecs[6]  = '{32'h38600005, 1'b0, 32'h0};
    vecs[7]  = '{enc(30, 1, 2, 3, 0, 266, 0), 1'b0, 32'h0};
    vecs[8]  = '{enc(31, 1, 2, 3, 0, 267, 0), 1'b0, 32'h0};
    vecs[9]  = '{enc(31, 1, 2, 3, 0, 284, 0), 1'b0, 32'h0};
    vecs[10] = '{enc(31, 2, 2, 2, 1, 266, 1), 1'b1, enc(31, 2, 2, 2, 1, 266, 1)};

    u_if.in_valid = 1'b0; u_if.in_instr = '0; u_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_instr = '0; s_if.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", u_if.in_ready, 1);
    check("rst_out_valid", u_if.out_valid, 0);
    check("rst_fifo_count", fcount, 0);
    check("rst_illegal", ill, 0);
    check("rst_illegal_cnt", ill_cnt, 0);
    check("rst_fields", {u_if.PO, u_if.rt, u_if.ra, u_if.rb, u_if.OE, u_if.XO, u_if.Rc}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // first word latency
    u_if.out_ready = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.in_instr = 32'h7C632214;
    check("lat_in_ready", u_if.in_ready, 1);
    exp_q.push_back(enc(31, 3, 3, 4, 0, 266, 0));
    @(negedge clk);
    u_if.in_valid = 1'b0;
    check("lat_cycle1_valid", u_if.out_valid, 0);
    check("lat_cycle1_count", fcount, 1);
    @(negedge clk);
    check("lat_cycle2_valid", u_if.out_valid, 1);
    check("add_PO", u_if.PO, 31);
    check("add_rt", u_if.rt, 3);
    check("add_ra", u_if.ra, 3);
    check("add_rb", u_if.rb, 4);
    check("add_OE", u_if.OE, 0);
    check("add_XO", u_if.XO, 266);
    check("add_Rc", u_if.Rc, 0);
    drain("lat_drain");
    check("lat_no_illegal", ill_pulses, 0);

    // illegal word between two adds
    hs0 = hs_cnt;
    push(enc(31, 7, 1, 2, 0, 266, 0), 1'b1, enc(31, 7, 1, 2, 0, 266, 0));
    push(32'h38600005, 1'b0, 32'h0);
    push(enc(31, 8, 1, 2, 0, 266, 0), 1'b1, enc(31, 8, 1, 2, 0, 266, 0));
    drain("ill_drain");
    check("ill_pulses", ill_pulses, 1);
    check("ill_cnt", ill_cnt, 1);
    check("ill_outputs", hs_cnt - hs0, 2);

    // fill to DEPTH with output stalled, then release
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(enc(31, 11 + i, 1, 2, 0, 266, 0), 1'b1, enc(31, 11 + i, 1, 2, 0, 266, 0));
    check("full_count", fcount, 4);
    check("full_in_ready", u_if.in_ready, 0);
    check("full_hold_valid", u_if.out_valid, 1);
    check("full_hold_rt", u_if.rt, 11);
    @(negedge clk);
    check("full_stable_rt", u_if.rt, 11);
    hs0 = hs_cnt;
    u_if.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("b2b_valid", u_if.out_valid, 1);
      @(negedge clk);
    end
    check("b2b_end_valid", u_if.out_valid, 0);
    check("b2b_count", hs_cnt - hs0, 5);

    // vector table
    for (int i = 0; i < 11; i++) push(vecs[i].instr, vecs[i].legal, vecs[i].exp);
    drain("table_drain");
    check("table_ill_cnt", ill_cnt, exp_ill);
    check("table_ill_pulses", ill_pulses, ill_total);

    // randomized traffic against the reference model
    pending = 1'b0;
    cur = '0;
    for (int c = 0; c < 400; c++) begin
      u_if.out_ready = ($urandom_range(0, 3) != 0);
      if (!pending && $urandom_range(0, 2) != 0) begin
        cur = gen_word();
        pending = 1'b1;
      end
      u_if.in_valid = pending;
      u_if.in_instr = cur;
      if (pending && u_if.in_ready) begin
        if (ref_legal(cur)) exp_q.push_back(ref_fields(cur));
        else begin
          exp_ill++;
          ill_total++;
        end
        pending = 1'b0;
      end
      @(negedge clk);
    end
    u_if.in_valid = 1'b0;
    drain("rand_drain");
    check("rand_ill_cnt", ill_cnt, exp_ill);
    check("rand_ill_pulses", ill_pulses, ill_total);

    // reset with words buffered and one held at the output
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(enc(31, 20 + i, 3, 4, 0, 40, 0), 1'b1, enc(31, 20 + i, 3, 4, 0, 40, 0));
    check("mid_count", fcount, 3);
    check("mid_valid", u_if.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", u_if.out_valid, 0);
    check("mid_rst_count", fcount, 0);
    check("mid_rst_in_ready", u_if.in_ready, 1);
    check("mid_rst_ill_cnt", ill_cnt, 0);
    exp_q.delete();
    exp_ill = 0;
    hs0 = hs_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    u_if.out_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("mid_no_stale", hs_cnt - hs0, 0);
    check("mid_after_valid", u_if.out_valid, 0);
    push(32'h7C8300D1, 1'b1, enc(31, 4, 3, 0, 0, 104, 1));
    drain("mid_alive_drain");
    check("mid_alive_count", hs_cnt - hs0, 1);

    // counter saturation on the CNT_W=4 instance
    for (int i = 0; i < 17; i++) begin
      s_if.in_valid = 1'b1;
      s_if.in_instr = enc(14, i % 32, 1, 2, 0, 266, 0);
      check("sat_in_ready", s_if.in_ready, 1);
      @(negedge clk);
      if (i == 14) begin
        s_if.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("sat_cnt_15", s_cnt, 15);
      end
    end
    s_if.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("sat_cnt_final", s_cnt, 15);
    check("sat_pulses", s_pulses, 17);
    check("sat_out_valid", s_if.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
